// File: rtl/frame_loader_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the UART-to-BRAM image loader and the VGA side.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package frame_loader_pkg;

  // Loader FSM states; FULL is only reachable in one-shot (non-wrapping) mode
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    FULL     = 2'd2
  } ld_state_t;

  // Default frame geometry (512 x 392 pixels)
  localparam int FRAME_W = 512;
  localparam int FRAME_H = 392;
  localparam int FRAME_PIX_DEFAULT = FRAME_W * FRAME_H;

  // 12-bit RGB colours shared with the VGA timing/colour logic
  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_WHITE = 12'hFFF;
  localparam logic [11:0] COLOR_RED   = 12'hF00;
  localparam logic [11:0] COLOR_GREEN = 12'h0F0;
  localparam logic [11:0] COLOR_BLUE  = 12'h00F;

  // Width of a byte index counting 0..bpp-1; never narrower than one bit
  function automatic int idx_w(input int bpp);
    return (bpp > 1) ? $clog2(bpp) : 1;
  endfunction

endpackage

// File: rtl/pixel_packer.sv
`timescale 1ns/1ps
// Shifts UART bytes MSB-first into a pixel word and flags the byte that completes it.
// Latency: pix_valid_o/pix_data_o are combinational with the completing byte.
// Backpressure: none; one byte may be offered every cycle, clr_i wins over byte_vld_i.
module pixel_packer #(
  parameter int BYTES_PER_PIX = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clr_i,
  input  logic                       byte_vld_i,
  input  logic [7:0]                 byte_dat_i,
  output logic                       pix_valid_o,
  output logic [8*BYTES_PER_PIX-1:0] pix_data_o
);
  import frame_loader_pkg::*;

  localparam int PIX_W = 8 * BYTES_PER_PIX;
  localparam int IDX_W = idx_w(BYTES_PER_PIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIX - 1);

  logic [PIX_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;

  // Next shift/index: the new byte enters at the LSB so the first byte ends up at the MSB
  always_comb begin
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    pix_data_o  = PIX_W'({shift_q, byte_dat_i});
    pix_valid_o = byte_vld_i && !clr_i && (byte_idx_q == LAST_IDX);
    if (clr_i) begin
      shift_d    = '0;
      byte_idx_d = '0;
    end else if (byte_vld_i) begin
      shift_d    = pix_data_o;
      byte_idx_d = (byte_idx_q == LAST_IDX) ? '0 : byte_idx_q + 1'b1;
    end
  end

  // Byte shift register and position counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
`timescale 1ns/1ps
// Packs UART bytes into pixels and writes them to BRAM port A at a frame-bounded address.
// Latency: wr_en/wr_data/frame_done one cycle after the completing rx_ready strobe.
// Backpressure: none; bytes dropped while FULL or on frame_restart. Optional: UART_FRAME_LOADER_TIMEOUT_EN.
module uart_frame_loader #(
  parameter  int BYTES_PER_PIX = 3,
  parameter  int FRAME_PIX     = 200704,
  parameter  int ADDR_W        = 18,
  parameter  int WRAP          = 1,
  parameter  int TIMEOUT_CYC   = 100000,
  localparam int PIX_W         = 8 * BYTES_PER_PIX
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              frame_restart,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              full,
  output logic [7:0]        frame_cnt
);
  import frame_loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  ld_state_t         state_q;
  logic              wr_en_q, frame_done_q, full_q;
  logic [ADDR_W-1:0] addr_q, pix_addr;
  logic [PIX_W-1:0]  data_q;
  logic [7:0]        frame_cnt_q;
  logic              accept, tmo_hit, pix_valid;
  logic [PIX_W-1:0]  pix_data;

  assign accept = rx_ready && !frame_restart && (state_q != FULL);

  // Address of the pixel being assembled: advance once the previous write has been presented
  always_comb begin
    pix_addr = addr_q;
    if (wr_en_q) begin
      if (addr_q == LAST_ADDR) pix_addr = (WRAP != 0) ? '0 : addr_q;
      else                     pix_addr = addr_q + 1'b1;
    end
  end

`ifdef UART_FRAME_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = (state_q == ASSEMBLE) && !rx_ready && (tmo_q == TW'(TIMEOUT_CYC - 1));

  // Idle-cycle counter while a pixel is partially assembled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                         tmo_q <= '0;
    else if (state_q != ASSEMBLE || rx_ready || tmo_hit) tmo_q <= '0;
    else                                                 tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  pixel_packer #(
    .BYTES_PER_PIX (BYTES_PER_PIX)
  ) u_packer (
    .clk         (clk),
    .resetn      (resetn),
    .clr_i       (frame_restart || tmo_hit),
    .byte_vld_i  (accept),
    .byte_dat_i  (rx_data),
    .pix_valid_o (pix_valid),
    .pix_data_o  (pix_data)
  );

  // Loader FSM with registered write, address, frame-end and frame-count outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      full_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      frame_cnt_q  <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      addr_q       <= pix_addr;
      if (frame_restart) begin
        state_q <= IDLE;
        full_q  <= 1'b0;
        addr_q  <= '0;
      end else if (tmo_hit) begin
        state_q <= IDLE;
      end else if (accept) begin
        if (pix_valid) begin
          wr_en_q <= 1'b1;
          data_q  <= pix_data;
          state_q <= IDLE;
          if (pix_addr == LAST_ADDR) begin
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 1'b1;
            if (WRAP == 0) begin
              state_q <= FULL;
              full_q  <= 1'b1;
            end
          end
        end else begin
          state_q <= ASSEMBLE;
        end
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign frame_done = frame_done_q;
  assign full       = full_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

- Parametrised successor to the fixed 3-byte pixel assembler and 18-bit write-address counter in the UART-to-BRAM image path.
- Packs a stream of UART bytes into pixels of `BYTES_PER_PIX` bytes and issues one write per pixel to BRAM port A, with a sequential, frame-bounded address.
- Adds an end-of-frame pulse, wrap and one-shot frame modes, synchronous restart and an optional inter-byte timeout resync.
- Sits between `uart_basic` (rx side) and the image `blk_mem_gen` port A, on the 100 MHz clock.

## Interface
Parameters:
- `BYTES_PER_PIX`, 3: bytes per pixel, legal range 1..4; `PIX_W = 8*BYTES_PER_PIX`.
- `FRAME_PIX`, 200704: pixels per frame (512×392).
- `ADDR_W`, 18: write-address width; must satisfy `FRAME_PIX <= 2**ADDR_W`.
- `WRAP`, 1: 1 = restart at address 0 after a full frame; 0 = hold full until `frame_restart`.
- `TIMEOUT_CYC`, 100000: idle cycles that discard a partial pixel; used only with the timeout macro.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `resetn` in 1: async active-low reset.
- `rx_ready` in 1: one-cycle byte strobe from the UART.
- `rx_data` in 8: received byte, valid while `rx_ready` is high.
- `frame_restart` in 1: synchronous pulse; clears the pixel in progress and resets the address to 0.
- `wr_en` out 1: one-cycle BRAM write enable.
- `wr_addr` out ADDR_W: BRAM write address.
- `wr_data` out PIX_W: assembled pixel.
- `frame_done` out 1: one-cycle pulse on the last pixel of a frame.
- `full` out 1: high while holding a complete frame (`WRAP=0` only).
- `frame_cnt` out 8: number of completed frames, wraps modulo 256.

## Operation
- Byte order: the first byte of a pixel goes to `wr_data[PIX_W-1 -: 8]`, so it is MSB-first; for 24-bit pixels this is R, G, B.
- States:
  - `IDLE`: no bytes held.
  - `ASSEMBLE`: `byte_idx` is 1..BYTES_PER_PIX-1.
  - `FULL`: reachable only when `WRAP=0`.
- Byte handling:
  - Each `rx_ready` shifts in `rx_data` and increments `byte_idx`.
  - On the byte that completes the pixel: `wr_en` pulses, `byte_idx` returns to 0 and the state returns to `IDLE`.
- Address rules:
  - `wr_addr` holds the current pixel address during the `wr_en` cycle and increments the cycle after.
  - When the pixel written at `FRAME_PIX-1` completes, `frame_done` pulses with that `wr_en` and `frame_cnt` increments.
  - The address then goes to 0 when `WRAP=1`; when `WRAP=0` the block enters `FULL`.
- `FULL`: all `rx_ready` strobes are ignored; `full` is 1. Only `frame_restart` or reset leaves `FULL`.
- `frame_restart`: has priority over `rx_ready` in the same cycle, and that byte is discarded. Next cycle: `byte_idx=0`, `wr_addr=0`, state `IDLE`; `frame_cnt` is unchanged.
- `BYTES_PER_PIX=1`: every byte is a pixel; `ASSEMBLE` is never entered.
- Arithmetic: unsigned only. The address compare is against `FRAME_PIX-1` at `ADDR_W` bits; there is no reliance on natural overflow.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `frame_done=0`, `full=0`, `frame_cnt=0`, state `IDLE`.
- Latency: `wr_en`, `wr_data` and `frame_done` are registered and assert on the cycle after the final byte's `rx_ready`.
- Throughput: `rx_ready` may assert on consecutive cycles; one pixel is accepted every `BYTES_PER_PIX` strobes with no stall.
- `wr_data` and `wr_addr` stay stable through the whole `wr_en` cycle. `wr_data` holds its value afterwards.
- `frame_done` is exactly one cycle wide and coincident with `wr_en`.
- A reset assertion mid-frame immediately forces all reset values; any partial pixel is lost.

## Configuration
- Macro: `UART_FRAME_LOADER_TIMEOUT_EN`.
- Defined:
  - A counter of width `$clog2(TIMEOUT_CYC+1)` counts cycles without `rx_ready` while in `ASSEMBLE`.
  - On reaching `TIMEOUT_CYC`, the partial pixel is discarded and the state returns to `IDLE`. `wr_addr` is unchanged and no write occurs.
  - Each `rx_ready` clears the counter.
- Undefined:
  - No counter is built; a partial pixel waits indefinitely.
  - `TIMEOUT_CYC` is unused.

## Structure
- Package `frame_loader_pkg`:
  - state enum `ld_state_t` {`IDLE`, `ASSEMBLE`, `FULL`};
  - default frame constants `FRAME_W=512`, `FRAME_H=392`;
  - `COLOR_*` constants shared with the VGA side.
- Sub-module: `pixel_packer` (byte shift register plus `byte_idx`, asserts `pix_valid`). The parent owns the FSM, address, frame count and timeout.

## Test plan
- Reset then bytes 0xAA, 0xBB, 0xCC (`BYTES_PER_PIX=3`) → one `wr_en` the cycle after the 3rd strobe, `wr_data=0xAABBCC`, `wr_addr=0`. Next pixel is written at `wr_addr=1`.
- `FRAME_PIX=4`, `WRAP=1`, 12 bytes → 4 writes at addresses 0..3, `frame_done` with the write at 3, `frame_cnt=1`. Byte 13 starts a pixel at address 0.
- `WRAP=0`, same stream plus 3 extra bytes → `full=1`, no 5th write. `frame_restart` → `full=0`, next pixel written at address 0.
- Two bytes, then `frame_restart` coincident with the 3rd `rx_ready` → no write. The next 3 bytes produce a pixel from those bytes only, at address 0.
- With `UART_FRAME_LOADER_TIMEOUT_EN` and `TIMEOUT_CYC=50`: one byte, 60 idle cycles, then 3 bytes → a single write of the last 3 bytes at address 0.
- `resetn` low mid-pixel at address 7 → all outputs 0 asynchronously. After release, 3 bytes are written at address 0.
